// File: rtl/hs32_fetch_q.sv
// hs32 instruction prefetch queue: sequential word fetch into a power-of-two FIFO with redirect-safe flush.
// Define HS32_FETCH_BYPASS_EN to let a beat reach decode in the same cycle when the queue is empty.
module hs32_fetch_q #(
    parameter int unsigned   DW         = 32,
    parameter int unsigned   AW         = 32,
    parameter int unsigned   DEPTH_LOG2 = 2,
    parameter int unsigned   STEP       = 4,
    parameter logic [AW-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] dtr,
    output logic          reqm,
    input  logic          rdym,
    output logic [DW-1:0] instd,
    output logic [AW-1:0] pcd,
    output logic          rdyd,
    input  logic          reqd,
    input  logic [AW-1:0] newpc,
    input  logic          flush
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [AW-1:0]       pendPc_q, pendPc_d;
    logic [PW-1:0]       wp_q, wp_d;
    logic [PW-1:0]       rp_q, rp_d;
    logic [DW-1:0]       memData_q [DEPTH];
    logic [AW-1:0]       memPc_q   [DEPTH];

    logic [PW-1:0]         fill;
    logic                  full;
    logic                  empty;
    logic                  beat;
    logic                  bypassHit;
    logic                  push;
    logic                  popFifo;
    logic [DEPTH_LOG2-1:0] wIdx;
    logic [DEPTH_LOG2-1:0] rIdx;

    assign fill  = wp_q - rp_q;
    assign full  = (fill == PW'(DEPTH));
    assign empty = (wp_q == rp_q);
    assign wIdx  = wp_q[DEPTH_LOG2-1:0];
    assign rIdx  = rp_q[DEPTH_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            pendPc_q <= RESET_PC;
            wp_q     <= '0;
            rp_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                memData_q[i] <= '0;
                memPc_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pendPc_q <= pendPc_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            if (push) begin
                memData_q[wIdx] <= dtr;
                memPc_q[wIdx]   <= pc_q;
            end
        end
    end

    // A flush with a beat still outstanding parks in DRAIN so the arbiter sees a stable request;
    // that beat is thrown away and the latest redirect target is taken up when it lands.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pendPc_d = pendPc_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        push     = 1'b0;
        popFifo  = 1'b0;
        if (state_q == RUN) begin
            if (flush) begin
                wp_d = '0;
                rp_d = '0;
                if (reqm && !rdym) begin
                    state_d  = DRAIN;
                    pendPc_d = newpc;
                end else begin
                    pc_d = newpc;
                end
            end else begin
                popFifo = rdyd && reqd && !bypassHit;
                push    = beat && !(bypassHit && reqd);
                if (beat) begin
                    pc_d = pc_q + AW'(STEP);
                end
                if (push) begin
                    wp_d = wp_q + 1'b1;
                end
                if (popFifo) begin
                    rp_d = rp_q + 1'b1;
                end
            end
        end else begin
            if (flush) begin
                wp_d = '0;
                rp_d = '0;
            end
            if (rdym) begin
                state_d = RUN;
                pc_d    = flush ? newpc : pendPc_q;
            end else if (flush) begin
                pendPc_d = newpc;
            end
        end
    end

    // pc is left untouched on entry to DRAIN, so it doubles as the held bus address there.
    always_comb begin
        reqm  = !reset && ((state_q == DRAIN) || !full);
        addr  = pc_q;
        beat  = reqm && rdym;
`ifdef HS32_FETCH_BYPASS_EN
        bypassHit = (state_q == RUN) && !flush && empty && beat;
`else
        bypassHit = 1'b0;
`endif
        rdyd  = !reset && !flush && (state_q == RUN) && (!empty || bypassHit);
        instd = bypassHit ? dtr  : memData_q[rIdx];
        pcd   = bypassHit ? pc_q : memPc_q[rIdx];
    end

endmodule

// File: tb/tb_hs32_fetch_q.sv
// Self-checking bench for hs32_fetch_q: directed steps with a queue scoreboard of {word, fetch address}.
// Expectations follow HS32_FETCH_BYPASS_EN when it is defined for the build.
module tb_hs32_fetch_q;
`ifdef HS32_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] dtr;
    logic        reqm;
    logic        rdym;
    logic [31:0] instd;
    logic [31:0] pcd;
    logic        rdyd;
    logic        reqd;
    logic [31:0] newpc;
    logic        flush;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] mPc;
    logic [31:0] mPend;
    bit          mDrain;
    logic [63:0] sbQ [$];
    bit          cReqm;
    bit          cRdyd;
    bit          cBypass;
    logic [63:0] head;
    logic [31:0] savedAddr;

    hs32_fetch_q #(
        .DW(32), .AW(32), .DEPTH_LOG2(2), .STEP(4), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .dtr(dtr), .reqm(reqm), .rdym(rdym),
        .instd(instd), .pcd(pcd), .rdyd(rdyd), .reqd(reqd), .newpc(newpc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and compare against the scoreboard model.
    task automatic applyStimulus(input bit rdymV, input logic [31:0] dtrV, input bit reqdV,
                                 input bit flushV, input logic [31:0] newpcV);
        @(negedge clk);
        reset = 1'b0;
        rdym  = rdymV;
        dtr   = dtrV;
        reqd  = reqdV;
        flush = flushV;
        newpc = newpcV;
        #1;
        cReqm   = mDrain || (sbQ.size() < DEPTH);
        cBypass = BYPASS && !mDrain && !flushV && (sbQ.size() == 0) && cReqm && rdymV;
        cRdyd   = !flushV && !mDrain && ((sbQ.size() != 0) || cBypass);
        checkOutput("reqm", {63'd0, reqm}, {63'd0, cReqm});
        checkOutput("rdyd", {63'd0, rdyd}, {63'd0, cRdyd});
        checkOutput("addr", {32'd0, addr}, {32'd0, mPc});
        if (cRdyd) begin
            head = cBypass ? {dtrV, mPc} : sbQ[0];
            checkOutput("instd", {32'd0, instd}, {32'd0, head[63:32]});
            checkOutput("pcd", {32'd0, pcd}, {32'd0, head[31:0]});
        end
    endtask

    task automatic commit();
        if (flush) begin
            sbQ.delete();
            if (!mDrain) begin
                if (cReqm && !rdym) begin
                    mDrain = 1'b1;
                    mPend  = newpc;
                end else begin
                    mPc = newpc;
                end
            end else if (rdym) begin
                mDrain = 1'b0;
                mPc    = newpc;
            end else begin
                mPend = newpc;
            end
        end else if (mDrain) begin
            if (rdym) begin
                mDrain = 1'b0;
                mPc    = mPend;
            end
        end else begin
            if (cRdyd && reqd && !cBypass) void'(sbQ.pop_front());
            if (cReqm && rdym && !(cBypass && reqd)) sbQ.push_back({dtr, mPc});
            if (cReqm && rdym) mPc = mPc + 32'd4;
        end
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rdym  = 1'b0;
        dtr   = '0;
        reqd  = 1'b0;
        flush = 1'b0;
        newpc = '0;
        mPc    = 32'h100;
        mPend  = 32'h100;
        mDrain = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("resetReqm", {63'd0, reqm}, 64'd0);
        checkOutput("resetRdyd", {63'd0, rdyd}, 64'd0);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("resetInstd", {32'd0, instd}, 64'd0);
        checkOutput("resetPcd", {32'd0, pcd}, 64'd0);
        checkOutput("resetAddr", {32'd0, addr}, 64'h100);
        commit();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hA000 + i, 1'b0, 1'b0, 32'h0);
            checkOutput("fillAddr", {32'd0, addr}, 64'h100 + 64'(4 * i));
            if (i == 1) begin
                checkOutput("firstRdyd", {63'd0, rdyd}, 64'd1);
                checkOutput("firstPcd", {32'd0, pcd}, 64'h100);
            end
            commit();
        end
        applyStimulus(1'b1, 32'hBAD0, 1'b0, 1'b0, 32'h0);
        checkOutput("fullReqm", {63'd0, reqm}, 64'd0);
        commit();

        applyStimulus(1'b1, 32'hBAD1, 1'b1, 1'b0, 32'h0);
        checkOutput("popInstd", {32'd0, instd}, 64'hA000);
        commit();
        applyStimulus(1'b1, 32'hA004, 1'b0, 1'b0, 32'h0);
        checkOutput("refillReqm", {63'd0, reqm}, 64'd1);
        checkOutput("refillAddr", {32'd0, addr}, 64'h110);
        commit();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("refullReqm", {63'd0, reqm}, 64'd0);
        commit();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'hC000 + i, 1'b1, 1'b0, 32'h0);
            checkOutput("streamRdyd", {63'd0, rdyd}, 64'd1);
            commit();
        end

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        savedAddr = addr;
        checkOutput("flushRdyd", {63'd0, rdyd}, 64'd0);
        commit();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("drainHold", {32'd0, addr}, {32'd0, savedAddr});
        commit();
        applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0);
        checkOutput("drainHold2", {32'd0, addr}, {32'd0, savedAddr});
        commit();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("redirectAddr", {32'd0, addr}, 64'h200);
        commit();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hE000 + i, 1'b1, 1'b0, 32'h0);
            checkOutput("noDead", {63'd0, (instd === 32'hDEAD)}, 64'd0);
            commit();
        end

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h280);
        commit();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        checkOutput("dflushRdyd1", {63'd0, rdyd}, 64'd0);
        commit();
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1, 32'h400);
        checkOutput("dflushRdyd2", {63'd0, rdyd}, 64'd0);
        commit();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("dflushAddr", {32'd0, addr}, 64'h400);
        checkOutput("dflushEmpty", {63'd0, rdyd}, 64'd0);
        commit();

        applyStimulus(1'b1, 32'hF00D, 1'b0, 1'b1, 32'hFFFFFFFC);
        commit();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h5000 + i, 1'b1, 1'b0, 32'h0);
            if (i == 0) checkOutput("wrapAddr0", {32'd0, addr}, 64'hFFFFFFFC);
            if (i == 1) checkOutput("wrapAddr1", {32'd0, addr}, 64'h0);
            commit();
        end

        applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h500);
        commit();
        applyStimulus(1'b1, 32'h1234, 1'b1, 1'b0, 32'h0);
        checkOutput("bypassRdyd", {63'd0, rdyd}, {63'd0, BYPASS});
        commit();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("bypassNextRdyd", {63'd0, rdyd}, {63'd0, !BYPASS});
        commit();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        commit();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/hs32_fetch_q.md
# hs32_fetch_q

Parametrised instruction prefetch queue for the hs32 core, the successor to the fixed 32-bit, 4-entry fetch unit. It issues sequential word reads to the memory arbiter and buffers the returned words in a power-of-two FIFO. It hands them to decode together with each word's fetch address. Flush handling is redirect-safe: a memory beat already in flight when a flush arrives is drained and discarded, never enqueued.

## Interface
- `DW`, 32: instruction/data width.
- `AW`, 32: address width.
- `DEPTH_LOG2`, 2: FIFO depth = 2^DEPTH_LOG2 entries; legal range 1..6.
- `STEP`, 4: address increment per fetched word.
- `RESET_PC`, 0: PC loaded by reset.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `addr` out AW: fetch address to arbiter.
- `dtr` in DW: read data from arbiter.
- `reqm` out 1: address valid / read request.
- `rdym` in 1: read data valid; a beat completes on `reqm && rdym`.
- `instd` out DW: head instruction to decode.
- `pcd` out AW: fetch address of `instd`.
- `rdyd` out 1: `instd`/`pcd` valid.
- `reqd` in 1: decode accepts; a pop occurs on `rdyd && reqd`.
- `newpc` in AW: redirect target.
- `flush` in 1: redirect; empties queue and restarts at `newpc`.

## Operation
- Storage: DW+AW bits per entry; wp/rp are DEPTH_LOG2+1 bits, wrap mod 2^(DEPTH_LOG2+1); fill = wp - rp; full = fill == 2^DEPTH_LOG2; empty = wp == rp.
- Reset values: pc = RESET_PC, wp = rp = 0, state RUN, `reqm` = 0, `rdyd` = 0, `instd` = 0, `pcd` = 0 (entries cleared).
- `addr` = pc in RUN, = held address in DRAIN.
- `reqm` = !reset && (state==DRAIN || !full).
- `rdyd` = !reset && !flush && state==RUN && !empty (see bypass).
- Push (RUN, no flush): on `reqm && rdym` write {dtr, pc} at wp, wp+1, pc += STEP (mod 2^AW).
- Pop: on `rdyd && reqd` rp+1. Push and pop in the same cycle are both legal when not full; a push is never possible while full because `reqm` = 0.
- States:
  - RUN → DRAIN on `flush && reqm && !rdym`: save `newpc` to pend_pc, hold addr.
  - RUN stays on `flush && (!reqm || rdym)`: pc = `newpc`, any beat that cycle is discarded.
  - DRAIN → RUN on `rdym`: beat discarded, pc = pend_pc.
  - DRAIN with another `flush`: pend_pc = latest `newpc` (latest wins). If `rdym` is also high that cycle, go to RUN with pc = that `newpc`.
- Every flush: wp = rp = 0.
- Reset has priority over flush, push and pop. Reset mid-DRAIN returns to RUN; the arbiter is expected to abandon the beat on reset.

## Timing
- Bus contract: while `reqm && !rdym`, `addr` is stable and `reqm` stays high, including across a flush (DRAIN).
- Memory-to-decode latency: beat at cycle n → `rdyd` at n+1 (n with bypass, queue empty).
- Flush at cycle n: `rdyd` = 0 at n. First new address is on `addr` at n+1 (RUN case) or the cycle after the draining `rdym` (DRAIN case).
- Full throughput: one push and one pop per cycle sustained when 0 < fill < depth.
- Full queue with no pop: `reqm` low until the cycle after a pop.

## Configuration
- `HS32_FETCH_BYPASS_EN` defined: when state==RUN, !flush, empty and `reqm && rdym`, then `rdyd` = 1, `instd` = `dtr`, `pcd` = `addr` combinationally. If `reqd` is high the word is consumed and not written (wp unchanged, pc advances); otherwise it is written normally. This adds a comb path `rdym`/`dtr` → `rdyd`/`instd`.
- Undefined: no bypass; outputs are driven from FIFO storage only; latency is 1 cycle minimum.

## Test plan
- Reset with RESET_PC=0x100, rdym always 1, reqd 0 → addr 0x100,0x104,0x108,0x10C; `reqm` falls after 4 beats; `rdyd` rises the cycle after the first beat with pcd=0x100.
- Full queue, pulse reqd once → exactly one pop, `reqm` high next cycle at addr 0x110, entry refilled.
- Flush newpc=0x200 while reqm high and rdym low; rdym 2 cycles later with dtr=0xDEAD → addr held stable until rdym, 0xDEAD never appears on instd, next addr 0x200.
- Two flushes (0x300 then 0x400) during DRAIN, rdym on the second → pc = 0x400, queue empty, rdyd 0 during both flushes.
- Wrap: AW=32, RESET_PC=0xFFFFFFFC → second addr 0x00000000, pcd sequence matches.
- With HS32_FETCH_BYPASS_EN, empty queue, reqd=1, rdym with dtr=0x1234 → rdyd=1 and instd=0x1234 the same cycle, wp unchanged; without the macro, rdyd rises the following cycle.
